// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drains an 8-deep synchronous FIFO one byte at a time and sends each byte
//   as an 8N1 UART frame: one start bit (0), DATA_W data bits LSB first, and
//   one stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
//   A new byte is popped only after the previous frame has finished, so the
//   FIFO sees back-pressure whenever the serial line is slower than the
//   producer.
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   reset       in   synchronous active-low reset (0 = reset)
//   tx_en       in   1 = allowed to start new frames
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_rd_e
//   fifo_rd_e   out  FIFO read enable, one-cycle pulse per byte
//   tx          out  serial line, idles high
//   busy        out  high from FETCH through the end of STOP
//   byte_done   out  one-cycle pulse in the last cycle of the stop bit
//
// Timing (from a falling fifo_empty seen in IDLE at cycle N)
//   N+1 : FETCH, fifo_rd_e high
//   N+2 : LOAD, fifo_data captured into the shift register
//   N+3 : START, tx low
//   Frame is 10*CLKS_PER_BIT cycles; back-to-back frames are separated by
//   2 idle-high cycles (FETCH + LOAD).
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_e,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  state_e              state_q,     state_d;
  logic [BAUD_W-1:0]   baud_q,      baud_d;
  logic [BIT_W-1:0]    bit_q,       bit_d;
  logic [DATA_W-1:0]   shift_q,     shift_d;
  logic                tx_q,        tx_d;
  logic                rd_e_q,      rd_e_d;
  logic                busy_q,      busy_d;
  logic                byte_done_q, byte_done_d;

  // A new frame may start only when enabled and the FIFO has data in the
  // very cycle the decision is taken, so a pop never hits an empty FIFO.
  logic can_pop;
  assign can_pop = tx_en && !fifo_empty;

  logic baud_wrap;
  assign baud_wrap = (baud_q == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        if (can_pop) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d = fifo_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end

      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = can_pop ? FETCH : IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every output comes straight from a
  // flop and lines up with state_q in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d        = 1'b1;
    rd_e_d      = (state_d == FETCH);
    busy_d      = (state_d != IDLE);
    byte_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);

    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      rd_e_q      <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rd_e_q      <= rd_e_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_rd_e = rd_e_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx with CLKS_PER_BIT = 4. A small FIFO model feeds the
//   DUT; every byte pushed is also queued as an expected result. A UART
//   receiver samples tx mid-bit, pops the queue and compares each frame.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_e;
  logic       tx;
  logic       busy;
  logic       byte_done;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_e (fifo_rd_e),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  // ---------------------------------------------------------------- FIFO model
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] mem [8];
  int         cnt = 0;
  int         wp = 0;
  int         rp = 0;

  assign fifo_empty = (cnt == 0);

  always @(posedge clk) begin
    int inc;
    int dec;
    inc = (push && cnt < 8) ? 1 : 0;
    dec = (fifo_rd_e && cnt > 0) ? 1 : 0;
    if (dec == 1) begin
      fifo_data <= mem[rp];
      rp <= (rp + 1) % 8;
    end
    if (inc == 1) begin
      mem[wp] <= push_data;
      wp <= (wp + 1) % 8;
    end
    cnt <= cnt + inc - dec;
  end

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (fifo_rd_e === 1'b1) begin
      rd_cnt++;
      checks++;
      if (fifo_empty !== 1'b0) begin
        errors++;
        $display("FAIL rd_while_empty: fifo_rd_e=1 with fifo_empty=%b (want 0)", fifo_empty);
      end
    end
    if (byte_done === 1'b1) done_cnt++;
  end

  // UART receiver / scoreboard. Start detected at the first negedge with tx
  // low (half a cycle into the start bit); later samples are at 1.5 cycles
  // into each bit. A reset during the frame discards the lost byte.
  always begin : rx_proc
    logic [7:0] rx;
    logic [7:0] exp;
    logic       sb;
    logic       pb;
    bit         ab;
    @(negedge clk);
    if (reset === 1'b1 && tx === 1'b0) begin
      rx = 8'h00;
      sb = 1'b1;
      pb = 1'b0;
      ab = 1'b0;
      for (int k = 1; k <= 37; k++) begin
        @(negedge clk);
        if (reset !== 1'b1) begin
          ab = 1'b1;
          break;
        end
        if (k == 1) sb = tx;
        else if (k >= 5 && k <= 33 && ((k - 1) % 4) == 0) rx[(k - 5) / 4] = tx;
        else if (k == 37) pb = tx;
      end
      if (ab) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got frame %02h, want no frame", rx);
        end else begin
          exp = exp_q.pop_front();
          if (rx !== exp) begin
            errors++;
            $display("FAIL rx_data: got %02h, want %02h", rx, exp);
          end
        end
        checks++;
        if (sb !== 1'b0 || pb !== 1'b1) begin
          errors++;
          $display("FAIL rx_framing: start=%b stop=%b, want start=0 stop=1", sb, pb);
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    push = 1'b1;
    push_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_rd(input int max, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (fifo_rd_e !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (fifo_rd_e !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: fifo_rd_e never rose within %0d cycles", name, max);
    end
  endtask

  task automatic wait_done(input int max, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (byte_done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (byte_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: byte_done never rose within %0d cycles", name, max);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (fifo_rd_e !== 1'b0) begin errors++; $display("FAIL reset_rd_e: got %b want 0", fifo_rd_e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (byte_done !== 1'b0) begin errors++; $display("FAIL reset_byte_done: got %b want 0", byte_done); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic [9:0] bits;
    int rd0;
    int dn0;
    b = 8'hA5;
    bits = {1'b1, b, 1'b0};
    rd0 = rd_cnt;
    dn0 = done_cnt;
    tx_en = 1'b1;
    push_byte(b);
    @(negedge clk);
    checks++;
    if (fifo_rd_e !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: fifo_rd_e=%b one cycle after empty fell, want 1", fifo_rd_e);
      wait_rd(20, "single_rd");
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_fetch: got %b want 1", busy); end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_load_tx: got %b want 1", tx); end
    for (int j = 0; j < 10 * CPB; j++) begin
      @(negedge clk);
      checks++;
      if (tx !== bits[j / CPB]) begin
        errors++;
        $display("FAIL single_tx cycle %0d: got %b want %b", j, tx, bits[j / CPB]);
      end
      checks++;
      if (byte_done !== (j == 10 * CPB - 1)) begin
        errors++;
        $display("FAIL single_byte_done cycle %0d: got %b want %b", j, byte_done, (j == 10 * CPB - 1));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL single_busy cycle %0d: got %b want 1", j, busy);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    checks++;
    if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt - rd0); end
    checks++;
    if (done_cnt - dn0 != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt - dn0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [8];
    int rd0;
    bytes = '{8'h01, 8'h09, 8'h07, 8'h03, 8'h04, 8'h06, 8'h08, 8'h0A};
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) push_byte(bytes[i]);
    tx_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      wait_done(80, "burst_done");
      if (f < 7) begin
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || fifo_rd_e !== 1'b1) begin
          errors++;
          $display("FAIL burst_gap1 frame %0d: tx=%b rd_e=%b want tx=1 rd_e=1", f, tx, fifo_rd_e);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL burst_gap2 frame %0d: tx=%b want 1", f, tx); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL burst_start frame %0d: tx=%b want 0", f, tx); end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_cnt - rd0 != 8) begin errors++; $display("FAIL burst_rd_count: got %0d want 8", rd_cnt - rd0); end
    checks++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL burst_empty: got %b want 1", fifo_empty); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy: got %b want 0", busy); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL burst_scoreboard: %0d frames missing, want 0", exp_q.size()); end
  endtask

  task automatic test_tx_en();
    int rd0;
    bit bad;
    tx_en = 1'b0;
    push_byte(8'h5A);
    push_byte(8'hC3);
    bad = 1'b0;
    rd0 = rd_cnt;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_e !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || rd_cnt != rd0) begin
      errors++;
      $display("FAIL txen_hold: line activity with tx_en=0 (rd pulses %0d, want 0)", rd_cnt - rd0);
    end
    tx_en = 1'b1;
    wait_rd(20, "txen_rd");
    repeat (8) @(negedge clk);
    tx_en = 1'b0;
    wait_done(80, "txen_done");
    rd0 = rd_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (rd_cnt != rd0) begin errors++; $display("FAIL txen_no_pop: got %0d pops want 0", rd_cnt - rd0); end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL txen_idle: busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
    checks++;
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL txen_left: fifo_empty=%b want 0", fifo_empty); end
    tx_en = 1'b1;
    wait_done(80, "txen_drain");
    tx_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int rd0;
    int dn0;
    tx_en = 1'b0;
    push_byte(8'hFF);
    push_byte(8'h3C);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    tx_en = 1'b1;
    wait_rd(20, "rst_rd");
    // fetch at F; start bit spans F+2..F+5, data bit 3 spans F+18..F+21
    repeat (19) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_bit3: busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_e !== 1'b0 || byte_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: tx=%b busy=%b rd_e=%b done=%b want 1 0 0 0", tx, busy, fifo_rd_e, byte_done);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_rd(20, "rst_resume_rd");
    wait_done(80, "rst_resume_done");
    tx_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rd_cnt - rd0 != 2) begin errors++; $display("FAIL rst_rd_count: got %0d want 2", rd_cnt - rd0); end
    checks++;
    if (done_cnt - dn0 != 1) begin errors++; $display("FAIL rst_done_count: got %0d want 1", done_cnt - dn0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_scoreboard: %0d frames missing, want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_en();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
